// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline control types for the stall/flush sequencer
package cpu_types_pkg;

  typedef enum logic [1:0] {
    SEQ_RUN,
    SEQ_DWAIT,
    SEQ_HALTED
  } seq_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_LOAD   = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - sequencer hazard inputs and latch controls (perf ports under PIPELINE_SEQ_PERF_EN)
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);
  logic ihit;
  logic dhit;
  logic dmemREN;
  logic dmemWEN;
  logic freeze;
  logic threeInstrFlush;
  logic halt_mem;

  logic pc_en;
  logic fd_en;
  logic dx_en;
  logic xm_en;
  logic mw_en;
  logic fd_flush;
  logic dx_flush;
  logic xm_flush;
  logic mw_flush;
  logic halt;
  logic err;
`ifdef PIPELINE_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [CNT_W-1:0] halted_at;
`endif

  modport seq (
    input  ihit, dhit, dmemREN, dmemWEN, freeze, threeInstrFlush, halt_mem,
    output pc_en, fd_en, dx_en, xm_en, mw_en,
    output fd_flush, dx_flush, xm_flush, mw_flush, halt, err
`ifdef PIPELINE_SEQ_PERF_EN
    , output stall_cycles, flush_count, halted_at
`endif
  );

  modport tb (
    output ihit, dhit, dmemREN, dmemWEN, freeze, threeInstrFlush, halt_mem,
    input  pc_en, fd_en, dx_en, xm_en, mw_en,
    input  fd_flush, dx_flush, xm_flush, mw_flush, halt, err
`ifdef PIPELINE_SEQ_PERF_EN
    , input stall_cycles, flush_count, halted_at
`endif
  );

endinterface

// File: rtl/pipeline_sequencer_wdog_counter.sv
// rtl/pipeline_sequencer_wdog_counter.sv - counter with clear/increment, optional saturation, threshold hit
module seq_wdog_counter #(
  parameter int         W      = 32,
  parameter bit         SAT    = 1'b1,
  parameter logic [W-1:0] THRESH = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         hit
);

  logic [W-1:0] count_nxt;

  // Clear with inc loads 1, so the first stalled cycle is already counted.
  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = {{(W-1){1'b0}}, inc};
    else if (inc && !(SAT && (&count)))
      count_nxt = count + 1'b1;
  end

  // Hit looks at the value being loaded so a sticky flag can be set on the same edge.
  assign hit = (count_nxt >= THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else
      count <= count_nxt;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush sequencer for the 5-stage pipeline; perf counters under PIPELINE_SEQ_PERF_EN
module pipeline_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  pipeline_sequencer_if.seq     bus
);

  seq_state_t  state, state_nxt;
  stage_ctrl_t fd, dx, xm, mw;
  logic        dstall, pc_en, redirect;
  logic        halt_q, err_q;
  logic        wdog_clr, wdog_inc, wdog_hit;
  logic [CNT_W-1:0] wdog_count_unused;

  assign dstall = (bus.dmemREN | bus.dmemWEN) & ~bus.dhit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= SEQ_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_RUN, SEQ_DWAIT: begin
        if (dstall)
          state_nxt = SEQ_DWAIT;
        else if (bus.halt_mem)
          state_nxt = SEQ_HALTED;
        else
          state_nxt = SEQ_RUN;
      end
      SEQ_HALTED: state_nxt = SEQ_HALTED;
      default:    state_nxt = SEQ_RUN;
    endcase
  end

  // DWAIT with the miss resolved falls through to the same rules as RUN.
  always_comb begin
    pc_en    = 1'b0;
    redirect = 1'b0;
    fd       = STAGE_HOLD;
    dx       = STAGE_HOLD;
    xm       = STAGE_HOLD;
    mw       = STAGE_HOLD;
    if (!RST && state != SEQ_HALTED && !dstall) begin
      if (bus.halt_mem) begin
        mw = STAGE_LOAD;
      end else if (bus.threeInstrFlush) begin
        pc_en    = 1'b1;
        redirect = 1'b1;
        fd       = STAGE_BUBBLE;
        dx       = STAGE_BUBBLE;
        xm       = STAGE_BUBBLE;
        mw       = STAGE_LOAD;
      end else if (bus.freeze) begin
        dx = STAGE_BUBBLE;
        xm = STAGE_LOAD;
        mw = STAGE_LOAD;
      end else if (!bus.ihit) begin
        fd = STAGE_BUBBLE;
        dx = STAGE_LOAD;
        xm = STAGE_LOAD;
        mw = STAGE_LOAD;
      end else begin
        pc_en = 1'b1;
        fd    = STAGE_LOAD;
        dx    = STAGE_LOAD;
        xm    = STAGE_LOAD;
        mw    = STAGE_LOAD;
      end
    end
  end

  assign wdog_inc = dstall & (state != SEQ_HALTED);
  assign wdog_clr = (state != SEQ_DWAIT) | ~dstall;

  seq_wdog_counter #(
    .W      (CNT_W),
    .SAT    (1'b1),
    .THRESH (CNT_W'(WDOG_CYCLES))
  ) u_wdog (
    .clk   (CLK),
    .rst   (RST),
    .clr   (wdog_clr),
    .inc   (wdog_inc),
    .count (wdog_count_unused),
    .hit   (wdog_hit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      halt_q <= halt_q | (state_nxt == SEQ_HALTED);
      err_q  <= err_q | wdog_hit;
    end
  end

  assign bus.pc_en    = pc_en;
  assign bus.fd_en    = fd.en;
  assign bus.dx_en    = dx.en;
  assign bus.xm_en    = xm.en;
  assign bus.mw_en    = mw.en;
  assign bus.fd_flush = fd.flush;
  assign bus.dx_flush = dx.flush;
  assign bus.xm_flush = xm.flush;
  assign bus.mw_flush = mw.flush;
  assign bus.halt     = halt_q;
  assign bus.err      = err_q;

`ifdef PIPELINE_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] halted_at_q;
  logic             stall_hit_unused, flush_hit_unused, cycle_hit_unused;

  seq_wdog_counter #(.W(CNT_W), .SAT(1'b0)) u_stall_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .inc   (~pc_en & (state != SEQ_HALTED)),
    .count (bus.stall_cycles),
    .hit   (stall_hit_unused)
  );

  seq_wdog_counter #(.W(CNT_W), .SAT(1'b0)) u_flush_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .inc   (redirect),
    .count (bus.flush_count),
    .hit   (flush_hit_unused)
  );

  seq_wdog_counter #(.W(CNT_W), .SAT(1'b0)) u_cycle_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (1'b0),
    .inc   (1'b1),
    .count (cycle_count),
    .hit   (cycle_hit_unused)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      halted_at_q <= '0;
    else if (state != SEQ_HALTED && state_nxt == SEQ_HALTED)
      halted_at_q <= cycle_count;
  end

  assign bus.halted_at = halted_at_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - scoreboard bench for pipeline_sequencer
module tb_pipeline_sequencer;

  localparam int WDOG = 8;

  // Input vector bits: {RST, ihit, dhit, dmemREN, dmemWEN, freeze, threeInstrFlush, halt_mem}
  localparam logic [7:0] V_RST    = 8'b1000_0000;
  localparam logic [7:0] V_IDLE   = 8'b0100_0000;
  localparam logic [7:0] V_FRZ    = 8'b0100_0100;
  localparam logic [7:0] V_MISS   = 8'b0101_0000;
  localparam logic [7:0] V_HIT    = 8'b0111_0000;
  localparam logic [7:0] V_BRANCH = 8'b0000_0110;
  localparam logic [7:0] V_NOI    = 8'b0000_0000;
  localparam logic [7:0] V_ST_H   = 8'b0100_1001;
  localparam logic [7:0] V_ST_HIT = 8'b0110_1001;
  localparam logic [7:0] V_H_BR   = 8'b0100_0011;

  logic CLK = 1'b0;
  logic RST;

  pipeline_sequencer_if #(.CNT_W(32)) bus ();

  pipeline_sequencer #(.CNT_W(32), .WDOG_CYCLES(WDOG)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [10:0] sb [$];

  int m_st = 0;
  int m_w  = 0;
  bit m_halt = 1'b0;
  bit m_err  = 1'b0;

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Output order: {pc, en fd/dx/xm/mw, flush fd/dx/xm/mw, halt, err}
  function automatic logic [10:0] model_out(input logic [7:0] v);
    logic [8:0] c;
    bit ds;
    c  = '0;
    ds = (v[4] | v[3]) & ~v[5];
    if (v[7]) return '0;
    if (m_st != 2 && !ds) begin
      if (v[0])       c = 9'b0_0001_0000;
      else if (v[1])  c = 9'b1_1111_1110;
      else if (v[2])  c = 9'b0_0111_0100;
      else if (!v[6]) c = 9'b0_1111_1000;
      else            c = 9'b1_1111_0000;
    end
    return {c, m_halt, m_err};
  endfunction

  task automatic model_update(input logic [7:0] v);
    bit ds;
    ds = (v[4] | v[3]) & ~v[5];
    if (v[7]) begin
      m_st = 0; m_w = 0; m_halt = 0; m_err = 0;
    end else begin
      case (m_st)
        0: begin
          if (ds) begin m_st = 1; m_w = 1; end
          else if (v[0]) begin m_st = 2; m_halt = 1; end
        end
        1: begin
          if (ds) begin
            m_w++;
            if (m_w == WDOG) m_err = 1;
          end else begin
            m_w = 0;
            if (v[0]) begin m_st = 2; m_halt = 1; end
            else m_st = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic [7:0] v);
    {RST, bus.ihit, bus.dhit, bus.dmemREN, bus.dmemWEN,
     bus.freeze, bus.threeInstrFlush, bus.halt_mem} = v;
    sb.push_back(model_out(v));
    #1;
    check(tag, {bus.pc_en, bus.fd_en, bus.dx_en, bus.xm_en, bus.mw_en,
                bus.fd_flush, bus.dx_flush, bus.xm_flush, bus.mw_flush,
                bus.halt, bus.err}, sb.pop_front());
    @(posedge CLK);
    model_update(v);
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] r;
    {RST, bus.ihit, bus.dhit, bus.dmemREN, bus.dmemWEN,
     bus.freeze, bus.threeInstrFlush, bus.halt_mem} = V_RST;
    @(negedge CLK);
    step("reset", V_RST);
    step("run", V_IDLE);
    step("run", V_IDLE);

    step("load_use", V_FRZ);
    step("after_freeze", V_IDLE);

    for (int i = 0; i < 4; i++) step("dmiss_wait", V_MISS);
    step("dmiss_hit", V_HIT);
    step("dmiss_back_run", V_IDLE);

    for (int i = 0; i < 5; i++) step("pre_rst_wait", V_MISS);
    step("rst_mid_dwait", V_RST);
    step("rst_release", V_IDLE);

    step("branch_imiss_freeze", V_BRANCH);
    step("imiss", V_NOI);
    step("halt_beats_branch_pre", V_IDLE);

    for (int i = 0; i < 10; i++) step("wdog_wait", V_MISS);
    step("wdog_hit_clears", V_HIT);
    step("err_sticky", V_IDLE);
    step("err_sticky2", V_FRZ);

    step("reset2", V_RST);
    step("store_halt_wait", V_ST_H);
    step("store_halt_wait", V_ST_H);
    step("store_halt_dhit", V_ST_HIT);
    for (int i = 0; i < 100; i++) begin
      r = 8'($urandom);
      r[7] = 1'b0;
      step("halted_hold", r);
    end

    step("reset3", V_RST);
    step("halt_vs_branch", V_H_BR);
    step("halted_after_branch", V_IDLE);
    step("reset4", V_RST);

    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      r[7] = ($urandom_range(0, 39) == 0);
      r[0] = ($urandom_range(0, 24) == 0);
      step("random", r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush sequencer for the 5-stage core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches plus PC).
Consumes the hazard unit's freeze and threeInstrFlush, the cache hit strobes and the MEM-stage halt.
Produces per-latch enable/flush, the PC enable, a sticky halt and a dmem-wait watchdog error.
One instance per core.

Parameters:
CNT_W, 32, width of watchdog and perf counters
WDOG_CYCLES, 1024, consecutive dmem-wait cycles before err asserts (must be ≥2 and < 2**CNT_W)

Ports:
CLK  in  1  core clock, rising edge
RST  in  1  asynchronous, active-high reset
ihit  in  1  icache returned the current fetch this cycle
dhit  in  1  dcache completed the MEM-stage access this cycle
dmemREN  in  1  MEM-stage load pending
dmemWEN  in  1  MEM-stage store pending
freeze  in  1  load-use hazard (from hazard unit)
threeInstrFlush  in  1  taken branch/jump resolved; squash 3 younger instrs
halt_mem  in  1  halt instruction is in MEM stage
pc_en  out  1  PC register loads next PC
fd_en, dx_en, xm_en, mw_en  out  1 each  latch enables
fd_flush, dx_flush, xm_flush, mw_flush  out  1 each  load bubble when enabled
halt  out  1  sticky core halted
err  out  1  sticky dmem watchdog expiry

Behaviour:
- Reset: state=RUN, halt=0, err=0, wdog=0, perf counters 0. Every enable and flush output is 0 while RST is high.
- FSM states: RUN, DWAIT, HALTED. Outputs are combinational from state+inputs; halt, err and counters are registered.
- dstall = (dmemREN|dmemWEN) & ~dhit.
- RUN, priority order:
  1. dstall: all en=0, pc_en=0, no flush. Next state DWAIT; wdog <= 1.
  2. halt_mem (no dstall): mw_en=1, all other en=0, pc_en=0. Next state HALTED; halt=1 from the next cycle.
  3. threeInstrFlush: pc_en=1 (redirect, ihit ignored); fd/dx/xm/mw en=1; fd_flush=dx_flush=xm_flush=1. Overrides freeze and ~ihit.
  4. freeze: pc_en=0, fd_en=0; dx_en=1, dx_flush=1; xm_en=mw_en=1.
  5. ~ihit: pc_en=0; fd_en=1, fd_flush=1; dx/xm/mw en=1.
  6. Otherwise: all en=1, no flush.
- DWAIT:
  - dstall still true: everything held. wdog increments, saturating.
  - When wdog reaches WDOG_CYCLES: err <= 1, sticky; the core keeps waiting.
  - dstall clears (dhit, or the request drops): the same cycle is evaluated with the RUN rules (items 2-6). wdog <= 0. Next state RUN.
- HALTED: all en=0, pc_en=0, flushes 0. halt stays 1; exited only by RST.
- Simultaneous events:
  - dstall blocks halt and redirect until dhit.
  - halt_mem beats threeInstrFlush.
  - dhit and halt_mem in the same DWAIT cycle → HALTED next.
- RST mid-operation: immediate return to the reset values regardless of state.

Optional Feature:
PIPELINE_SEQ_PERF_EN
- Defined: adds outputs stall_cycles [CNT_W], flush_count [CNT_W], halted_at [CNT_W].
  - stall_cycles: increments each cycle pc_en=0 while not HALTED.
  - flush_count: increments each cycle threeInstrFlush is honoured.
  - halted_at: free-running cycle count captured on entry to HALTED.
  - All three wrap modulo 2**CNT_W and reset to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg gets: typedef enum logic [1:0] {SEQ_RUN, SEQ_DWAIT, SEQ_HALTED} seq_state_t; and a packed struct stage_ctrl_t {en, flush}.
- A matching pipeline_sequencer_if carries modports seq and tb, in the same style as the other unit interfaces.
- One natural sub-module: seq_wdog_counter, a saturating counter with clear, increment and threshold-hit outputs.
  - Reused for the perf counters with saturation disabled.

Test Plan:
- Reset: RST=1 mid-DWAIT with wdog=5 → next cycle state RUN, all outputs 0, err=0. After release with ihit=1, all en=1.
- Load-use: freeze=1, ihit=1 for 1 cycle → pc_en=0, fd_en=0, dx_en=1, dx_flush=1. Next cycle all en=1.
- Dmem miss: dmemREN=1, dhit=0 for 4 cycles, then dhit=1 → 4 cycles of all en=0; on the dhit cycle all en=1; state back to RUN.
- Branch during icache miss: threeInstrFlush=1, ihit=0, freeze=1 → pc_en=1; fd/dx/xm_flush=1; mw_flush=0.
- Halt after store: dmemWEN=1, halt_mem=1, dhit=0 for 2 cycles, then dhit=1 → halt=1 one cycle later. halt stays 1 for 100 cycles with all en=0.
- Watchdog with WDOG_CYCLES=8: dmemREN=1, dhit never asserts → err=1 after the 8th wait cycle, and stays 1 after a later dhit.
